piece_queue_sequencer: RTL and testbench

- Sequences the pseudo-random piece source for the Tetris game.
- Samples the free-running random word every clock and reduces it to a piece type.
- Keeps a preview queue of upcoming pieces and hands the head piece to the game FSM on request.
- Rejects immediate repeats, with a bounded number of rerolls.

---
 rtl/tetris_pkg.sv | 15 +
 rtl/piece_shift_queue.sv | 63 ++++++
 rtl/piece_queue_sequencer.sv | 175 +++++++++++++++++
 tb/tb_piece_queue_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris piece sequencer.
package tetris_pkg;

  localparam int NUM_PIECES = 5;
  localparam int TYPE_W     = 3;

  typedef logic [TYPE_W-1:0] piece_t;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/piece_shift_queue.sv
// DEPTH-entry shift FIFO: pop shifts every entry down, push lands at the
// lowest free index after the pop, and a head write port serves hold swaps.
module piece_shift_queue #(
  parameter int DEPTH = 3,
  parameter int W     = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  logic               pop,
  input  logic [W-1:0]       push_data,
  input  logic               head_we,
  input  logic [W-1:0]       head_data,
  output logic [DEPTH*W-1:0] entries,
  output logic [3:0]         count
);

  logic [W-1:0] q_r   [DEPTH];
  logic [W-1:0] nxt_s [DEPTH];
  logic [3:0]   count_r;
  logic [3:0]   wr_idx_s;

  // Next queue contents: shift on pop, overwrite head on a swap, append on push.
  always_comb begin
    nxt_s    = q_r;
    wr_idx_s = count_r - {3'b000, pop};
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        nxt_s[i] = q_r[i+1];
      end
      nxt_s[DEPTH-1] = '0;
    end else begin
      nxt_s[0] = head_we ? head_data : q_r[0];
    end
    for (int i = 0; i < DEPTH; i++) begin
      nxt_s[i] = (push && (4'(i) == wr_idx_s)) ? push_data : nxt_s[i];
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= '0;
      end
      count_r <= 4'd0;
    end else begin
      q_r     <= nxt_s;
      count_r <= count_r - {3'b000, pop} + {3'b000, push};
    end
  end

  // Flatten the entries, queue[i] at bits [i*W +: W].
  always_comb begin
    entries = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i*W +: W] = q_r[i];
    end
  end

  assign count = count_r;

endmodule

// File: rtl/piece_queue_sequencer.sv
// Piece sequencer: reduces the random word to a piece type, rejects repeats of
// the tail with bounded rerolls, and feeds a preview queue. Optional hold slot
// is enabled with the HOLD_SLOT_EN macro.
module piece_queue_sequencer #(
  parameter int NUM_PIECES = tetris_pkg::NUM_PIECES,
  parameter int TYPE_W     = tetris_pkg::TYPE_W,
  parameter int DEPTH      = 3,
  parameter int MAX_REROLL = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [31:0]             rnd_data,
  input  logic                    piece_req,
  output logic                    piece_valid,
  output logic [TYPE_W-1:0]       piece_type,
  output logic [DEPTH*TYPE_W-1:0] preview_types,
  output logic [3:0]              queue_count,
  input  logic                    hold_req,
  output logic                    hold_valid,
  output logic [TYPE_W-1:0]       hold_type
);

  import tetris_pkg::*;

  seq_state_t          state_r;
  seq_state_t          state_nxt_s;
  logic [7:0]          reroll_r;
  logic [31:0]         cand_full_s;
  logic [TYPE_W-1:0]   cand_s;
  logic [TYPE_W-1:0]   tail_s;
  logic [TYPE_W-1:0]   head_s;
  logic [3:0]          count_s;
  logic [3:0]          post_cnt_s;
  logic [DEPTH*TYPE_W-1:0] entries_s;
  logic                pop_req_s;
  logic                hold_move_s;
  logic                hold_swap_s;
  logic                shift_s;
  logic                eval_s;
  logic                accept_s;
  logic                reject_s;
  logic                head_we_s;
  logic [TYPE_W-1:0]   head_data_s;

  assign cand_full_s = rnd_data % 32'(NUM_PIECES);
  assign cand_s      = cand_full_s[TYPE_W-1:0];
  assign head_s      = entries_s[TYPE_W-1:0];

  // Tail entry of the queue (index count-1); still valid after a pop shift.
  always_comb begin
    tail_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tail_s = (4'(i + 1) == count_s) ? entries_s[i*TYPE_W +: TYPE_W] : tail_s;
    end
  end

  // Accept/reject decision, evaluated against the post-pop queue.
  always_comb begin
    pop_req_s  = piece_req && piece_valid;
    shift_s    = pop_req_s || hold_move_s;
    post_cnt_s = count_s - {3'b000, shift_s};
    eval_s     = (state_r != S_INIT) && (post_cnt_s < 4'(DEPTH));
    accept_s   = eval_s && ((post_cnt_s == 4'd0) || (cand_s != tail_s) ||
                            (reroll_r == 8'(MAX_REROLL)));
    reject_s   = eval_s && !accept_s;
  end

  // Reroll counter: cleared by any accept, held while the queue is full.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      reroll_r <= 8'd0;
    end else if (accept_s) begin
      reroll_r <= 8'd0;
    end else if (reject_s) begin
      reroll_r <= reroll_r + 8'd1;
    end else begin
      reroll_r <= reroll_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= S_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_INIT:  state_nxt_s = S_FILL;
      S_FILL:  state_nxt_s = (count_s == 4'(DEPTH)) ? S_RUN : S_FILL;
      S_RUN:   state_nxt_s = S_RUN;
      default: state_nxt_s = S_INIT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    piece_valid = 1'b0;
    case (state_r)
      S_RUN:   piece_valid = (count_s != 4'd0);
      default: piece_valid = 1'b0;
    endcase
  end

`ifdef HOLD_SLOT_EN
  logic              hold_valid_r;
  logic [TYPE_W-1:0] hold_type_r;
  logic              hold_used_r;
  logic              hold_go_s;

  // One hold per piece; a simultaneous piece_req takes priority.
  always_comb begin
    hold_go_s   = hold_req && piece_valid && !piece_req && !hold_used_r;
    hold_move_s = hold_go_s && !hold_valid_r;
    hold_swap_s = hold_go_s && hold_valid_r;
  end

  // Hold slot and per-piece hold lockout.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_valid_r <= 1'b0;
      hold_type_r  <= '0;
      hold_used_r  <= 1'b0;
    end else if (pop_req_s) begin
      hold_used_r  <= 1'b0;
    end else if (hold_go_s) begin
      hold_valid_r <= 1'b1;
      hold_type_r  <= head_s;
      hold_used_r  <= 1'b1;
    end else begin
      hold_used_r  <= hold_used_r;
    end
  end

  assign head_we_s   = hold_swap_s;
  assign head_data_s = hold_type_r;
  assign hold_valid  = hold_valid_r;
  assign hold_type   = hold_type_r;
`else
  logic unused_hold_s;

  assign unused_hold_s = hold_req;
  assign hold_move_s   = 1'b0;
  assign hold_swap_s   = 1'b0;
  assign head_we_s     = 1'b0;
  assign head_data_s   = '0;
  assign hold_valid    = 1'b0;
  assign hold_type     = '0;
`endif

  piece_shift_queue #(
    .DEPTH (DEPTH),
    .W     (TYPE_W)
  ) u_queue (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept_s),
    .pop       (shift_s),
    .push_data (cand_s),
    .head_we   (head_we_s),
    .head_data (head_data_s),
    .entries   (entries_s),
    .count     (count_s)
  );

  assign piece_type    = head_s;
  assign preview_types = entries_s;
  assign queue_count   = count_s;

endmodule

// File: tb/tb_piece_queue_sequencer.sv
// Directed self-checking bench for piece_queue_sequencer (default parameters).
module tb_piece_queue_sequencer;

  logic        clk;
  logic        resetn;
  logic [31:0] rnd_data;
  logic        piece_req;
  logic        piece_valid;
  logic [2:0]  piece_type;
  logic [8:0]  preview_types;
  logic [3:0]  queue_count;
  logic        hold_req;
  logic        hold_valid;
  logic [2:0]  hold_type;

  int tests_run = 0;
  int failed    = 0;

  piece_queue_sequencer dut (
    .clk           (clk),
    .resetn        (resetn),
    .rnd_data      (rnd_data),
    .piece_req     (piece_req),
    .piece_valid   (piece_valid),
    .piece_type    (piece_type),
    .preview_types (preview_types),
    .queue_count   (queue_count),
    .hold_req      (hold_req),
    .hold_valid    (hold_valid),
    .hold_type     (hold_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; piece_req = 1'b0; hold_req = 1'b0; rnd_data = 32'd0;
    tick(); tick();
    tests_run++;
    if (queue_count !== 4'd0) begin failed++; $display("FAIL reset_count got %0d exp 0", queue_count); end
    tests_run++;
    if (piece_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %0b exp 0", piece_valid); end
    tests_run++;
    if (preview_types !== 9'd0) begin failed++; $display("FAIL reset_preview got %h exp 000", preview_types); end
    tests_run++;
    if (hold_valid !== 1'b0 || hold_type !== 3'd0) begin
      failed++; $display("FAIL reset_hold got %0b/%0d exp 0/0", hold_valid, hold_type);
    end
  endtask

  // Fill from reset with 0,1,2; a piece_req during fill must be ignored.
  task automatic test_fill();
    resetn = 1'b1; rnd_data = 32'd7;
    tick();  // S_INIT -> S_FILL, no accept
    tests_run++;
    if (queue_count !== 4'd0) begin failed++; $display("FAIL init_no_accept got %0d exp 0", queue_count); end
    rnd_data = 32'd0; tick();
    rnd_data = 32'd1; piece_req = 1'b1; tick(); piece_req = 1'b0;
    tests_run++;
    if (queue_count !== 4'd2) begin failed++; $display("FAIL fill_req_ignored got %0d exp 2", queue_count); end
    tests_run++;
    if (piece_valid !== 1'b0) begin failed++; $display("FAIL fill_valid_low got %0b exp 0", piece_valid); end
    rnd_data = 32'd2; tick();
    tests_run++;
    if (queue_count !== 4'd3 || piece_valid !== 1'b0) begin
      failed++; $display("FAIL fill_full_cycle4 got cnt %0d valid %0b exp 3/0", queue_count, piece_valid);
    end
    rnd_data = 32'd3; tick();
    tests_run++;
    if (piece_valid !== 1'b1) begin failed++; $display("FAIL fill_valid_cycle5 got %0b exp 1", piece_valid); end
    tests_run++;
    if (preview_types !== {3'd2, 3'd1, 3'd0}) begin
      failed++; $display("FAIL fill_preview got %h exp %h", preview_types, {3'd2, 3'd1, 3'd0});
    end
    tests_run++;
    if (piece_type !== 3'd0) begin failed++; $display("FAIL fill_head got %0d exp 0", piece_type); end
  endtask

  // Pop with a simultaneous push: count stays at DEPTH.
  task automatic test_pop();
    piece_req = 1'b1; rnd_data = 32'd8;
    tick(); piece_req = 1'b0;
    tests_run++;
    if (preview_types !== {3'd3, 3'd2, 3'd1}) begin
      failed++; $display("FAIL pop_preview got %h exp %h", preview_types, {3'd3, 3'd2, 3'd1});
    end
    tests_run++;
    if (queue_count !== 4'd3) begin failed++; $display("FAIL pop_count got %0d exp 3", queue_count); end
    tests_run++;
    if (piece_type !== 3'd1) begin failed++; $display("FAIL pop_head got %0d exp 1", piece_type); end
  endtask

  // Tail 4 with candidate 4: two rejects then a forced accept; counter then clears.
  task automatic test_reroll();
    piece_req = 1'b1; rnd_data = 32'd4; tick();   // {2,3,4}
    rnd_data = 32'd9; tick(); piece_req = 1'b0;   // pop, reject 1 -> {3,4}
    tests_run++;
    if (queue_count !== 4'd2) begin failed++; $display("FAIL reroll_rej1 got %0d exp 2", queue_count); end
    tick();                                       // reject 2
    tests_run++;
    if (queue_count !== 4'd2) begin failed++; $display("FAIL reroll_rej2 got %0d exp 2", queue_count); end
    tick();                                       // forced accept
    tests_run++;
    if (queue_count !== 4'd3 || preview_types !== {3'd4, 3'd4, 3'd3}) begin
      failed++; $display("FAIL reroll_forced got cnt %0d prev %h exp 3/%h", queue_count, preview_types, {3'd4, 3'd4, 3'd3});
    end
    piece_req = 1'b1; tick(); piece_req = 1'b0;   // pop, tail 4, reject again
    tests_run++;
    if (queue_count !== 4'd2) begin failed++; $display("FAIL reroll_cleared got %0d exp 2", queue_count); end
    rnd_data = 32'd10; tick();                    // cand 0 differs
    tests_run++;
    if (preview_types !== {3'd0, 3'd4, 3'd4} || queue_count !== 4'd3) begin
      failed++; $display("FAIL reroll_distinct got %h cnt %0d exp %h/3", preview_types, queue_count, {3'd0, 3'd4, 3'd4});
    end
  endtask

  // Mid-run reset with a pending pop, then refill from S_INIT.
  task automatic test_reset_mid();
    resetn = 1'b0; piece_req = 1'b1; rnd_data = 32'd1;
    tick();
    resetn = 1'b1; piece_req = 1'b0;
    tests_run++;
    if (queue_count !== 4'd0 || piece_valid !== 1'b0 || preview_types !== 9'd0) begin
      failed++; $display("FAIL midreset got cnt %0d valid %0b prev %h exp 0/0/000", queue_count, piece_valid, preview_types);
    end
    rnd_data = 32'd5; tick();
    tests_run++;
    if (queue_count !== 4'd0) begin failed++; $display("FAIL midreset_init got %0d exp 0", queue_count); end
    rnd_data = 32'd5; tick();
    rnd_data = 32'd6; tick();
    rnd_data = 32'd7; tick();
    tests_run++;
    if (piece_valid !== 1'b0) begin failed++; $display("FAIL midreset_early_valid got %0b exp 0", piece_valid); end
    tick();
    tests_run++;
    if (piece_valid !== 1'b1 || preview_types !== {3'd2, 3'd1, 3'd0}) begin
      failed++; $display("FAIL midreset_refill got valid %0b prev %h exp 1/%h", piece_valid, preview_types, {3'd2, 3'd1, 3'd0});
    end
  endtask

`ifdef HOLD_SLOT_EN
  task automatic test_hold();
    piece_req = 1'b1; rnd_data = 32'd4; tick();   // {1,2,4}
    rnd_data = 32'd3; tick(); piece_req = 1'b0;   // {2,4,3}
    hold_req = 1'b1; rnd_data = 32'd0; tick(); hold_req = 1'b0;
    tests_run++;
    if (hold_valid !== 1'b1 || hold_type !== 3'd2 || preview_types !== {3'd0, 3'd3, 3'd4}) begin
      failed++; $display("FAIL hold_move got %0b/%0d prev %h exp 1/2/%h", hold_valid, hold_type, preview_types, {3'd0, 3'd3, 3'd4});
    end
    hold_req = 1'b1; tick(); hold_req = 1'b0;
    tests_run++;
    if (hold_type !== 3'd2 || preview_types !== {3'd0, 3'd3, 3'd4}) begin
      failed++; $display("FAIL hold_second_ignored got %0d prev %h exp 2/%h", hold_type, preview_types, {3'd0, 3'd3, 3'd4});
    end
    piece_req = 1'b1; rnd_data = 32'd1; tick(); piece_req = 1'b0;  // {3,0,1}
    hold_req = 1'b1; tick(); hold_req = 1'b0;
    tests_run++;
    if (piece_type !== 3'd2 || hold_type !== 3'd3 || queue_count !== 4'd3) begin
      failed++; $display("FAIL hold_swap got head %0d hold %0d cnt %0d exp 2/3/3", piece_type, hold_type, queue_count);
    end
  endtask
`else
  task automatic test_hold_disabled();
    hold_req = 1'b1; rnd_data = 32'd3; tick(); hold_req = 1'b0;
    tests_run++;
    if (hold_valid !== 1'b0 || hold_type !== 3'd0 || preview_types !== {3'd2, 3'd1, 3'd0}) begin
      failed++; $display("FAIL hold_disabled got %0b/%0d prev %h exp 0/0/%h", hold_valid, hold_type, preview_types, {3'd2, 3'd1, 3'd0});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_pop();
    test_reroll();
    test_reset_mid();
`ifdef HOLD_SLOT_EN
    test_hold();
`else
    test_hold_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
